edge_timestamp_fifo: RTL and testbench

Timestamps single-cycle rising-edge pulses and buffers them for a slow consumer. It sits directly downstream of the posedge detector. Each accepted pulse captures a free-running cycle counter and an event sequence number into a show-ahead FIFO, which is drained over a valid/ready interface. It keeps sticky overflow and drop accounting so that software can detect lost events.

---
 rtl/edge_ts_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/edge_timestamp_fifo.sv | 83 ++++++++
 tb/tb_edge_timestamp_fifo.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_ts_pkg.sv
// Shared widths and entry layout for the edge timestamp FIFO.
// Entries are packed {seq, ts} with the sequence number in the MSBs.
package edge_ts_pkg;

  localparam int unsigned DEF_TS_W   = 32;
  localparam int unsigned DEF_SEQ_W  = 16;
  localparam int unsigned DEF_DROP_W = 16;
  localparam int unsigned DEF_DEPTH  = 16;

  function automatic int unsigned entry_width(int unsigned seq_w, int unsigned ts_w);
    return seq_w + ts_w;
  endfunction

  localparam int unsigned DEF_ENTRY_W = entry_width(DEF_SEQ_W, DEF_TS_W);

  typedef struct packed {
    logic [DEF_SEQ_W-1:0] seq;
    logic [DEF_TS_W-1:0]  ts;
  } entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output; the head word is read
// combinationally from storage. A write into a full FIFO is accepted when a read
// happens in the same cycle.
module sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == FullCnt);
  assign level = cnt_q;

  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  assign rd_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd) begin
        cnt_q <= cnt_q + (AW+1)'(1);
      end else if (do_rd && !do_wr) begin
        cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

  // Storage carries no reset; payload is only meaningful while non-empty.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/edge_timestamp_fifo.sv
// Timestamps accepted event pulses with a free-running cycle counter and a
// sequence number, buffering them for a valid/ready consumer with drop accounting.
module edge_timestamp_fifo
  import edge_ts_pkg::*;
#(
  parameter int unsigned TS_W   = DEF_TS_W,
  parameter int unsigned SEQ_W  = DEF_SEQ_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DROP_W = DEF_DROP_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     pe_in,
  input  logic                     ts_clr,
  input  logic                     ovf_clr,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [TS_W-1:0]          out_ts,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int unsigned EntryW = entry_width(SEQ_W, TS_W);

  logic [TS_W-1:0]   ts_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [DROP_W-1:0] drop_cnt_q;
  logic              overflow_q;

  logic              evt, push, pop, drop;
  logic              fifo_full, fifo_empty;
  logic [EntryW-1:0] rd_data;

  assign evt  = pe_in & en;
  assign pop  = out_valid & out_ready;
  assign push = evt & (~fifo_full | pop);
  assign drop = evt & ~push;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q       <= '0;
      seq_q      <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      ts_q <= ts_clr ? '0 : ts_q + TS_W'(1);
      // Dropped events still consume a sequence number so losses show as gaps.
      if (evt) seq_q <= seq_q + SEQ_W'(1);
      if (ovf_clr) begin
        drop_cnt_q <= drop ? DROP_W'(1) : '0;
        overflow_q <= drop;
      end else if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + DROP_W'(1);
      end
    end
  end

  sync_fifo #(
    .W     (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data ({seq_q, ts_q}),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign out_valid = ~fifo_empty;
  assign out_seq   = rd_data[EntryW-1 -: SEQ_W];
  assign out_ts    = rd_data[TS_W-1:0];
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_edge_timestamp_fifo.sv
// Bench for edge_timestamp_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_edge_timestamp_fifo;
  import edge_ts_pkg::*;

  localparam int unsigned DEPTH = DEF_DEPTH;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n, en, pe_in, ts_clr, ovf_clr, out_ready;
  logic                  out_valid;
  logic [DEF_TS_W-1:0]   out_ts;
  logic [DEF_SEQ_W-1:0]  out_seq;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic [DEF_DROP_W-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DEF_TS_W-1:0]   m_ts;
  logic [DEF_SEQ_W-1:0]  m_seq;
  logic [DEF_DROP_W-1:0] m_drop;
  logic                  m_ovf;
  entry_t                m_q[$];

  always #5 clk = ~clk;

  edge_timestamp_fifo #(
    .TS_W   (DEF_TS_W),
    .SEQ_W  (DEF_SEQ_W),
    .DEPTH  (DEPTH),
    .DROP_W (DEF_DROP_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pe_in     (pe_in),
    .ts_clr    (ts_clr),
    .ovf_clr   (ovf_clr),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_ts    (out_ts),
    .out_seq   (out_seq),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  // Advance one clock; the model consumes the inputs held during that cycle.
  task automatic step();
    bit     do_pop, ev, acc;
    entry_t e;
    @(posedge clk);
    if (!rst_n) begin
      m_ts   = '0;
      m_seq  = '0;
      m_drop = '0;
      m_ovf  = 1'b0;
      m_q.delete();
    end else begin
      do_pop = (m_q.size() != 0) && out_ready;
      ev     = pe_in && en;
      acc    = ev && ((m_q.size() < int'(DEPTH)) || do_pop);
      e.seq  = m_seq;
      e.ts   = m_ts;
      if (do_pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(e);
      if (ev) m_seq = m_seq + 1'b1;
      if (ovf_clr) begin
        m_drop = (ev && !acc) ? DEF_DROP_W'(1) : '0;
        m_ovf  = ev && !acc;
      end else if (ev && !acc) begin
        m_ovf = 1'b1;
        if (m_drop != '1) m_drop = m_drop + 1'b1;
      end
      m_ts = ts_clr ? '0 : m_ts + 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    en        = 1'b1;
    pe_in     = 1'b0;
    ts_clr    = 1'b0;
    ovf_clr   = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b want 0", out_valid);
    end
    checks++;
    if (level !== '0) begin
      errors++; $display("FAIL reset_level: got %0d want 0", level);
    end
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== '0) begin
      errors++; $display("FAIL reset_ovf: got ovf=%0b drop=%0d want 0/0", overflow, drop_cnt);
    end
    for (int i = 0; i < 20 && m_ts != 5; i++) step();
    pe_in = 1'b1;
    step();
    pe_in = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_ts !== 32'd5 || out_seq !== 16'd0) begin
      errors++;
      $display("FAIL first_event: got v=%0b ts=%0d seq=%0d want 1/5/0", out_valid, out_ts, out_seq);
    end
    checks++;
    if (level !== LW'(1)) begin
      errors++; $display("FAIL first_level: got %0d want 1", level);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || level !== '0) begin
      errors++; $display("FAIL first_pop: got v=%0b lvl=%0d want 0/0", out_valid, level);
    end
  endtask

  task automatic test_enable();
    do_reset();
    en    = 1'b0;
    pe_in = 1'b1;
    repeat (5) step();
    checks++;
    if (out_valid !== 1'b0 || level !== '0 || drop_cnt !== '0) begin
      errors++;
      $display("FAIL en_low: got v=%0b lvl=%0d drop=%0d want 0/0/0", out_valid, level, drop_cnt);
    end
    en = 1'b1;
    step();
    pe_in = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_seq !== 16'd0) begin
      errors++; $display("FAIL en_resume: got v=%0b seq=%0d want 1/0", out_valid, out_seq);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    pe_in = 1'b1;
    repeat (DEPTH + 3) step();
    pe_in = 1'b0;
    checks++;
    if (level !== LW'(16) || drop_cnt !== 16'd3 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_fill: got lvl=%0d drop=%0d ovf=%0b want 16/3/1", level, drop_cnt, overflow);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_seq !== DEF_SEQ_W'(i)) begin
        errors++; $display("FAIL ovf_drain: got v=%0b seq=%0d want 1/%0d", out_valid, out_seq, i);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    checks++;
    if (level !== '0) begin
      errors++; $display("FAIL ovf_empty: got %0d want 0", level);
    end
    pe_in = 1'b1;
    step();
    pe_in = 1'b0;
    checks++;
    if (out_seq !== 16'd19) begin
      errors++; $display("FAIL ovf_next_seq: got %0d want 19", out_seq);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    pe_in = 1'b1;
    repeat (DEPTH) step();
    out_ready = 1'b1;
    step();
    pe_in     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (level !== LW'(16) || drop_cnt !== '0 || out_seq !== 16'd1) begin
      errors++;
      $display("FAIL full_pop: got lvl=%0d drop=%0d seq=%0d want 16/0/1", level, drop_cnt, out_seq);
    end
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (out_seq !== DEF_SEQ_W'(i)) begin
        errors++; $display("FAIL full_pop_drain: got seq=%0d want %0d", out_seq, i);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_ts_clr();
    do_reset();
    for (int i = 0; i < 200 && m_ts != 100; i++) step();
    pe_in  = 1'b1;
    ts_clr = 1'b1;
    step();
    ts_clr = 1'b0;
    step();
    pe_in = 1'b0;
    checks++;
    if (out_ts !== 32'd100 || level !== LW'(2)) begin
      errors++; $display("FAIL ts_clr_capture: got ts=%0d lvl=%0d want 100/2", out_ts, level);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_ts !== 32'd0 || out_seq !== 16'd1) begin
      errors++; $display("FAIL ts_clr_zero: got ts=%0d seq=%0d want 0/1", out_ts, out_seq);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_ovf_clr();
    do_reset();
    pe_in = 1'b1;
    repeat (DEPTH + 2) step();
    ovf_clr = 1'b1;
    step();
    pe_in = 1'b0;
    checks++;
    if (drop_cnt !== 16'd1 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_clr_drop: got drop=%0d ovf=%0b want 1/1", drop_cnt, overflow);
    end
    step();
    ovf_clr = 1'b0;
    checks++;
    if (drop_cnt !== '0 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clr_only: got drop=%0d ovf=%0b want 0/0", drop_cnt, overflow);
    end
    pe_in = 1'b1;
    step();
    pe_in     = 1'b0;
    out_ready = 1'b1;
    repeat (12) step();
    out_ready = 1'b0;
    checks++;
    if (level !== LW'(4) || drop_cnt !== 16'd1) begin
      errors++; $display("FAIL pre_reset: got lvl=%0d drop=%0d want 4/1", level, drop_cnt);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || level !== '0 || overflow !== 1'b0 || drop_cnt !== '0) begin
      errors++;
      $display("FAIL mid_reset: got v=%0b lvl=%0d ovf=%0b drop=%0d want all 0",
               out_valid, level, overflow, drop_cnt);
    end
    pe_in = 1'b1;
    step();
    pe_in = 1'b0;
    checks++;
    if (out_ts !== 32'd0 || out_seq !== 16'd0) begin
      errors++; $display("FAIL post_reset_entry: got ts=%0d seq=%0d want 0/0", out_ts, out_seq);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    int rdy_pct;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rdy_pct   = ((c / 200) % 2 == 0) ? 20 : 80;
      pe_in     = ($urandom_range(0, 99) < 60);
      en        = ($urandom_range(0, 99) < 90);
      ts_clr    = ($urandom_range(0, 99) < 2);
      ovf_clr   = ($urandom_range(0, 99) < 3);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      rst_n     = ($urandom_range(0, 999) != 0);
      step();
      checks++;
      if (out_valid !== (m_q.size() != 0) || level !== LW'(m_q.size())) begin
        errors++;
        $display("FAIL rand_level c=%0d: got v=%0b lvl=%0d want %0b/%0d",
                 c, out_valid, level, m_q.size() != 0, m_q.size());
      end
      checks++;
      if (overflow !== m_ovf || drop_cnt !== m_drop) begin
        errors++;
        $display("FAIL rand_drop c=%0d: got ovf=%0b drop=%0d want %0b/%0d",
                 c, overflow, drop_cnt, m_ovf, m_drop);
      end
      if (m_q.size() != 0) begin
        checks++;
        if (out_ts !== m_q[0].ts || out_seq !== m_q[0].seq) begin
          errors++;
          $display("FAIL rand_head c=%0d: got ts=%0d seq=%0d want %0d/%0d",
                   c, out_ts, out_seq, m_q[0].ts, m_q[0].seq);
        end
      end
    end
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    test_reset();
    test_enable();
    test_overflow();
    test_full_pop();
    test_ts_clr();
    test_ovf_clr();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
